// File: rtl/store_buffer_if.sv
// store_buffer_if: CPU store/load ports and DataMemory port of the store buffer.
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW = 16,
    parameter int DW = 16
);
    logic                     st_valid;
    logic [AW-1:0]            st_addr;
    logic [DW-1:0]            st_data;
    logic                     st_ready;
    logic                     ld_req;
    logic [AW-1:0]            ld_addr;
    logic [DW-1:0]            ld_data;
    logic                     ld_stall;
    logic [AW-1:0]            mem_addr;
    logic [DW-1:0]            mem_wd;
    logic                     mem_write;
    logic                     mem_read;
    logic [DW-1:0]            mem_rdata;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    modport master (
        output st_valid, st_addr, st_data, ld_req, ld_addr, mem_rdata,
        input  st_ready, ld_data, ld_stall, mem_addr, mem_wd, mem_write, mem_read, count, empty
    );
    modport slave (
        input  st_valid, st_addr, st_data, ld_req, ld_addr, mem_rdata,
        output st_ready, ld_data, ld_stall, mem_addr, mem_wd, mem_write, mem_read, count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO in front of DataMemory with load forwarding,
// load-priority port arbitration and stall on partial byte overlap.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW = 16,
    parameter int DW = 16
) (
    input logic         Clk,
    input logic         Reset,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, idx;
    logic [PW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid, part;
    logic [DW-1:0]    fwd;
    logic             hit, ld_go, drain, push;
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off      = PW'(i) - head_q;
        assign valid[i] = {1'b0, off} < count_q;
        assign part[i]  = valid[i] & ((addr_q[i] == bus.ld_addr + AW'(1)) | (addr_q[i] + AW'(1) == bus.ld_addr));
    end
    // Walking oldest to youngest lets the last hit win, giving the newest data.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (valid[idx] && addr_q[idx] == bus.ld_addr) begin
                hit = 1'b1;
                fwd = data_q[idx];
            end
        end
    end
    always_comb begin
        bus.st_ready  = (count_q != (PW+1)'(DEPTH)) & ~Reset;
        bus.ld_stall  = bus.ld_req & (|part) & ~Reset;
        ld_go         = bus.ld_req & ~bus.ld_stall & ~Reset;
        drain         = ~ld_go & (count_q != '0) & ~Reset;
        push          = bus.st_valid & bus.st_ready;
        bus.mem_read  = ld_go;
        bus.mem_write = drain;
        bus.mem_addr  = ld_go ? bus.ld_addr : drain ? addr_q[head_q] : '0;
        bus.mem_wd    = drain ? data_q[head_q] : '0;
        bus.ld_data   = ~bus.ld_req ? '0 : hit ? fwd : bus.mem_rdata;
        bus.count     = count_q;
        bus.empty     = count_q == '0;
        addr_d        = addr_q;
        data_d        = data_q;
        if (push) begin
            addr_d[tail_q] = bus.st_addr;
            data_d[tail_q] = bus.st_data;
        end
        tail_d  = tail_q + PW'(push);
        head_d  = head_q + PW'(drain);
        count_d = count_q + (PW+1)'(push) - (PW+1)'(drain);
    end
    always_ff @(posedge Clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        if (Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus checked against a queue-based
// reference of the buffer plus a byte-array model of big-endian DataMemory.
module tb_store_buffer;
    typedef struct { logic [15:0] a; logic [15:0] d; } ent_t;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int errors = 0;
    int checks = 0;
    ent_t q [$];
    bit [7:0] mm   [65536];
    bit [7:0] dmem [65536];
    logic last_stall = 1'b0;
    logic [15:0] last_la = '0;
    store_buffer_if #(.DEPTH(4), .AW(16), .DW(16)) bus ();
    store_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    always #5 Clk = ~Clk;
    assign bus.mem_rdata = {dmem[bus.mem_addr], dmem[bus.mem_addr + 16'd1]};
    always @(posedge Clk) begin
        if (bus.mem_write) begin
            dmem[bus.mem_addr]         <= bus.mem_wd[15:8];
            dmem[bus.mem_addr + 16'd1] <= bus.mem_wd[7:0];
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                        input logic lr, input logic [15:0] la, input logic rs);
        logic part, hit, e_stall, go, dr, rdy;
        logic [15:0] fd, ea;
        @(negedge Clk);
        Reset = rs; bus.st_valid = sv; bus.st_addr = sa; bus.st_data = sd;
        bus.ld_req = lr; bus.ld_addr = la;
        #1;
        part = 1'b0; hit = 1'b0; fd = '0;
        foreach (q[i]) begin
            if (q[i].a == la + 16'd1 || q[i].a + 16'd1 == la) part = 1'b1;
            if (q[i].a == la) begin hit = 1'b1; fd = q[i].d; end
        end
        e_stall = lr & part & ~rs;
        go      = lr & ~e_stall & ~rs;
        dr      = ~go & (q.size() > 0) & ~rs;
        rdy     = (q.size() < 4) & ~rs;
        chk("st_ready", 32'(bus.st_ready), 32'(rdy));
        chk("ld_stall", 32'(bus.ld_stall), 32'(e_stall));
        chk("mem_read", 32'(bus.mem_read), 32'(go));
        chk("mem_write", 32'(bus.mem_write), 32'(dr));
        if (!rs) begin
            ea = go ? la : dr ? q[0].a : 16'h0;
            chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
            chk("mem_wd", 32'(bus.mem_wd), dr ? 32'(q[0].d) : 32'h0);
            if (!e_stall)
                chk("ld_data", 32'(bus.ld_data), !lr ? 32'h0 : hit ? 32'(fd) : 32'({mm[la], mm[la + 16'd1]}));
        end
        if (rs) q.delete();
        else begin
            if (dr) begin
                mm[q[0].a] = q[0].d[15:8];
                mm[q[0].a + 16'd1] = q[0].d[7:0];
                void'(q.pop_front());
            end
            if (sv && rdy) q.push_back('{a: sa, d: sd});
        end
        last_stall = e_stall;
        last_la = la;
        @(posedge Clk); #1;
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask
    initial begin
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
        bus.ld_req = 1'b0; bus.ld_addr = '0;
        step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        // simple store then drain
        step(1'b1, 16'h0004, 16'hABCD, 1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("dmem4", 32'(dmem[16'h0004]), 32'hAB);
        chk("dmem5", 32'(dmem[16'h0005]), 32'hCD);
        // fill with drains blocked by a held load, fifth store rejected
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0060 + 16'(2 * i), 16'h1000 + 16'(i), 1'b1, 16'h0020, 1'b0);
        chk("full_count", 32'(bus.count), 32'd4);
        idle(5);
        // forwarding from the youngest exact match
        step(1'b1, 16'h0010, 16'h1111, 1'b1, 16'h0040, 1'b0);
        step(1'b1, 16'h0010, 16'h2222, 1'b1, 16'h0040, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010, 1'b0);
        idle(3);
        // partial overlap stalls until drained
        step(1'b1, 16'h0011, 16'h3344, 1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010, 1'b0);
        chk("dmem10", 32'(dmem[16'h0010]), 32'h22);
        chk("dmem11", 32'(dmem[16'h0011]), 32'h33);
        chk("dmem12", 32'(dmem[16'h0012]), 32'h44);
        // three fill/drain rounds, store rejected when full during a drain
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 16'h0100 + 16'(8 * r + 2 * i), 16'(r * 16 + i), 1'b1, 16'h0020, 1'b0);
            step(1'b1, 16'h0200, 16'hDEAD, 1'b0, 16'h0, 1'b0);
            idle(4);
        end
        // reset discards pending stores
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0030 + 16'(2 * i), 16'hBEEF, 1'b1, 16'h0080, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        idle(3);
        chk("dmem30", 32'(dmem[16'h0030]), 32'h00);
        chk("dmem34", 32'(dmem[16'h0034]), 32'h00);
        // random traffic in a small address window to provoke overlaps
        for (int n = 0; n < 600; n++) begin
            logic lr;
            logic [15:0] la;
            lr = last_stall ? 1'b1 : ($urandom_range(0, 9) < 4);
            la = last_stall ? last_la : 16'($urandom_range(0, 15));
            step($urandom_range(0, 1) == 1, 16'($urandom_range(0, 15)), 16'($urandom),
                 lr, la, $urandom_range(0, 79) == 0);
        end
        idle(6);
        for (int a = 0; a < 512; a++) chk("dmem_final", 32'(dmem[a]), 32'(mm[a]));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
